// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte staging FIFO that paces launches into the UART transmitter (optional UART_TXF_WATERMARK_EN adds almost_full)
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 4
`ifdef UART_TXF_WATERMARK_EN
    ,
    parameter int AF_LEVEL     = DEPTH - 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tx_busy,
    input  logic              clr_ovf,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef UART_TXF_WATERMARK_EN
    ,
    output logic              almost_full
`endif
);

    localparam int TMR_W = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [TMR_W-1:0]    timer;
    logic                push;
    logic                pop;
    logic [ADDR_W:0]     count_next;

    // full/empty come straight from the occupancy counter, so no pointer-compare ambiguity
    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // a push while full is dropped even if a pop frees a slot on the same edge
    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && !empty && !tx_busy;

    // next occupancy; shared by the count register and the watermark flag
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (ADDR_W+1)'(1);
        end
    end

    // storage write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
        end
    end

    // sticky overflow; a new overflow beats a clear on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // launch sequencer: pop in IDLE, pulse in LAUNCH, then follow tx_busy or time out
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            timer    <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TXF_WATERMARK_EN
    // watermark tracks the same edge as count
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= (ADDR_W+1)'(AF_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_busy;
    logic       clr_ovf;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
`ifdef UART_TXF_WATERMARK_EN
    logic       almost_full;
`endif

    uart_tx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_busy  (tx_busy),
        .clr_ovf  (clr_ovf),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
`ifdef UART_TXF_WATERMARK_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         cnt_m = 0;
    bit         ovf_m = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         start_cyc_q[$];
    logic [7:0] last_data = 8'h00;
    int         starts = 0;
    bit         prev_start = 1'b0;
    int         busy_left = 0;
    bit         pending = 1'b0;
    bit         force_busy = 1'b0;
    int         busy_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit         acc;
        bit         ovf_ev;
        logic       busy_prev;
        logic [7:0] want;
        acc       = wr_en && (cnt_m < 16);
        ovf_ev    = wr_en && (cnt_m == 16);
        busy_prev = tx_busy;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            cnt_m      = 0;
            exp_q.delete();
            ovf_m      = 1'b0;
            last_data  = 8'h00;
            prev_start = 1'b0;
        end else begin
            if (acc) begin
                exp_q.push_back(wr_data);
                cnt_m++;
            end
            if (ovf_ev) ovf_m = 1'b1;
            else if (clr_ovf) ovf_m = 1'b0;
            if (tx_start) begin
                chk("start_twice", prev_start, 0);
                chk("start_busy_prev", busy_prev, 0);
                chk("start_has_data", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    chk("tx_data_order", tx_data, want);
                    cnt_m--;
                end
                last_data = tx_data;
                got_q.push_back(tx_data);
                start_cyc_q.push_back(cyc);
                starts++;
            end else begin
                chk("tx_data_hold", tx_data, last_data);
            end
            prev_start = tx_start;
        end
        chk("count", count, cnt_m);
        chk("empty", empty, cnt_m == 0);
        chk("full", full, cnt_m == 16);
        chk("overflow", overflow, ovf_m);
`ifdef UART_TXF_WATERMARK_EN
        chk("almost_full", almost_full, cnt_m >= 14);
`endif
        if (busy_left > 0) busy_left--;
        if (pending) begin
            busy_left = busy_len;
            pending   = 1'b0;
        end
        if (tx_start && !rst) pending = 1'b1;
        tx_busy = force_busy || (busy_left > 0);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() > 0 || pending || busy_left > 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (8) tick();
    endtask

    initial begin
        int c;
        int s0;
        int n;
        int n_acc;
        int pushes;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; tx_busy = 1'b0;

        // reset state
        tick();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) tick();

        // single byte latency
        busy_len = 3;
        s0 = starts;
        c = cyc;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        drain(40);
        chk("single_starts", starts - s0, 1);
        chk("single_latency", start_cyc_q[start_cyc_q.size()-1], c + 2);
        chk("single_data", last_data, 8'hA5);
        chk("single_empty", empty, 1);

        // burst with long busy frames
        busy_len = 20;
        got_q.delete();
        wr_en = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        drain(200);
        chk("burst_n", got_q.size(), 3);
        chk("burst_0", got_q[0], 8'h11);
        chk("burst_1", got_q[1], 8'h22);
        chk("burst_2", got_q[2], 8'h33);

        // fill to full, overflow, clear, release
        force_busy = 1'b1;
        tx_busy = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            if (i == 15) begin
                chk("fill_full", full, 1);
                chk("fill_count", count, 16);
                chk("fill_no_ovf", overflow, 0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);
        force_busy = 1'b0;
        busy_len = 2;
        got_q.delete();
        drain(400);
        chk("full_sent_n", got_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("full_order", got_q[i], 8'(i));
        end

        // busy never rises: timeout pacing
        busy_len = 0;
        start_cyc_q.delete();
        wr_en = 1'b1;
        wr_data = 8'h5A; tick();
        wr_data = 8'hC3; tick();
        wr_en = 1'b0;
        drain(100);
        chk("timeout_n", start_cyc_q.size(), 2);
        chk("timeout_gap", start_cyc_q[1] - start_cyc_q[0], 6);

        // random traffic across pointer wrap
        got_q.delete();
        n_acc = 0;
        pushes = 0;
        while (pushes < 40) begin
            busy_len = $urandom_range(0, 12);
            wr_en = ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom);
            if (wr_en) begin
                pushes++;
                if (cnt_m < 16) n_acc++;
            end
            tick();
        end
        wr_en = 1'b0;
        drain(2000);
        chk("wrap_sent", got_q.size(), n_acc);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // reset while a frame is in flight
        busy_len = 30;
        s0 = starts;
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        n = 0;
        while (starts == s0 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_first_start", starts - s0, 1);
        repeat (3) tick();
        chk("mid_queued", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_start", tx_start, 0);
        chk("mid_rst_data", tx_data, 0);
        s0 = starts;
        repeat (50) tick();
        chk("mid_silent", starts - s0, 0);
        wr_en = 1'b1; wr_data = 8'h7E;
        tick();
        wr_en = 1'b0;
        drain(100);
        chk("mid_resume_n", starts - s0, 1);
        chk("mid_resume_data", last_data, 8'h7E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
